// File: rtl/mem_loader.sv
// UART (8N1) program loader in front of the 256x8 memory: received bytes go to addresses 0.. while loading.
// Optional trailing checksum byte when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int LOAD_LEN     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  input  logic       start_i,
  input  logic [7:0] cpu_addr_i,
  input  logic [7:0] cpu_din_i,
  input  logic       cpu_we_i,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_din_o,
  output logic       mem_we_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       frame_err_o,
  output logic       csum_err_o,
  output logic [8:0] byte_cnt_o,
  output logic [1:0] rx_state_o,
  output logic [1:0] ld_state_o
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]    LEN      = 9'(LOAD_LEN);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE, L_CSUM} ld_state_t;
`else
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;
`endif

  logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          rx_ferr;

  ld_state_t     ld_state_q, ld_state_d;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic          ld_we;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic          csum_err_q, csum_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_s3_q     <= 1'b1;
      rx_state_q   <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      ld_state_q   <= L_IDLE;
      byte_cnt_q   <= '0;
      frame_err_q  <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      csum_err_q   <= 1'b0;
`endif
    end else begin
      rxd_s1_q     <= rxd_i;
      rxd_s2_q     <= rxd_s1_q;
      rxd_s3_q     <= rxd_s2_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ld_state_q   <= ld_state_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_err_q  <= frame_err_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      csum_err_q   <= csum_err_d;
`endif
    end
  end

  // Receiver: start bit re-checked at mid-bit, then every bit sampled one bit period apart.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rxd_s3_q && !rxd_s2_q) begin
          rx_state_d = R_START;
          cnt_d      = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rxd_s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d        = '0;
          byte_valid_d = rxd_s2_q;
          rx_ferr      = !rxd_s2_q;
          rx_state_d   = R_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Loader: a validated byte is presented to memory for the one cycle byte_valid_q is high.
  always_comb begin
    ld_state_d  = ld_state_q;
    byte_cnt_d  = byte_cnt_q;
    frame_err_d = frame_err_q | rx_ferr;
    ld_we       = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    csum_err_d  = csum_err_q;
`endif
    case (ld_state_q)
      L_IDLE, L_DONE: begin
        if (start_i) begin
          ld_state_d  = L_LOAD;
          byte_cnt_d  = '0;
          frame_err_d = rx_ferr;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d       = '0;
          csum_err_d  = 1'b0;
`endif
        end
      end
      L_LOAD: begin
        if (byte_valid_q) begin
          ld_we      = 1'b1;
          byte_cnt_d = byte_cnt_q + 9'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + shift_q;
          if (byte_cnt_d == LEN) ld_state_d = L_CSUM;
`else
          if (byte_cnt_d == LEN) ld_state_d = L_DONE;
`endif
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      L_CSUM: begin
        if (byte_valid_q) begin
          csum_err_d = (sum_q + shift_q) != 8'd0;
          ld_state_d = L_DONE;
        end
      end
`endif
      default: ld_state_d = L_IDLE;
    endcase
  end

  always_comb begin
`ifdef MEM_LOADER_CHECKSUM_EN
    busy_o     = (ld_state_q == L_LOAD) || (ld_state_q == L_CSUM);
    csum_err_o = csum_err_q;
`else
    busy_o     = (ld_state_q == L_LOAD);
    csum_err_o = 1'b0;
`endif
    mem_addr_o = busy_o ? byte_cnt_q[7:0] : cpu_addr_i;
    mem_din_o  = busy_o ? shift_q : cpu_din_i;
    mem_we_o   = busy_o ? ld_we : cpu_we_i;
  end

  assign done_o      = (ld_state_q == L_DONE);
  assign frame_err_o = frame_err_q;
  assign byte_cnt_o  = byte_cnt_q;
  assign rx_state_o  = rx_state_q;
  assign ld_state_o  = ld_state_q;

endmodule

// File: doc/mem_loader.md
# mem_loader

Serial program loader sitting directly upstream of the 256×8 data/program memory. It receives bytes on a UART line (8N1) and writes them to consecutive memory addresses starting at 0. While loading it owns the memory write port; otherwise it passes the CPU's address, data and write-enable straight through. It reports progress, completion and framing errors to the top level and debug LEDs.

## Interface
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal ≥ 4
- LOAD_LEN, 256, bytes per load; legal 1..256
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- rxd  in  1  UART receive line, idle high, asynchronous to clk
- start  in  1  one-cycle pulse, begins a load
- cpu_addr  in  8  CPU memory address
- cpu_din  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- mem_addr  out  8  to memory addr
- mem_din  out  8  to memory din
- mem_we  out  1  to memory we
- busy  out  1  load in progress; CPU writes blocked
- done  out  1  load completed; sticky until next start
- frame_err  out  1  sticky; a byte had stop bit = 0
- csum_err  out  1  checksum mismatch (see Configuration)
- byte_cnt  out  9  bytes written this load, 0..256

## Operation
- Synchronize rxd with two flops before any use.
- RX FSM: R_IDLE → R_START on synchronized falling edge; R_START waits CLKS_PER_BIT/2 and re-samples; low → R_DATA, high → R_IDLE (glitch, no error). R_DATA samples 8 bits, LSB first, every CLKS_PER_BIT cycles. R_STOP samples one bit later: 1 → byte valid, 0 → frame_err set, byte discarded. Then back to R_IDLE.
- Loader FSM: L_IDLE, L_LOAD, L_CSUM (macro only), L_DONE.
  - L_IDLE/L_DONE + start → L_LOAD; clears byte_cnt, done, frame_err, csum_err, checksum accumulator.
  - L_LOAD: each valid byte is written to address byte_cnt[7:0], then byte_cnt increments. When byte_cnt reaches LOAD_LEN → L_DONE (or L_CSUM).
  - start while busy is ignored.
- busy = 1 in L_LOAD/L_CSUM. When busy, mem_addr/mem_din come from the loader and mem_we is the loader's write strobe only; cpu_we is ignored. When not busy, all three mem_* outputs are combinational passthroughs of cpu_*.
- Bytes received in L_IDLE/L_DONE are discarded with no write. A framing error in those states still sets frame_err.
- A frame error does not advance byte_cnt. The next good byte is written to the same address.
- Checksum arithmetic is 8-bit modulo-256 sum of the written data bytes.

## Timing
- Reset values: busy=0, done=0, frame_err=0, csum_err=0, byte_cnt=0, RX and loader FSMs idle, loader write strobe 0. mem_* follow cpu_* immediately after reset.
- Reset asserted mid-load aborts the load on that edge. Already-written bytes remain unless the memory is reset too.
- Loader write: mem_we is high for exactly one cycle, on the cycle after the stop-bit sample that validated the byte. mem_addr and mem_din are stable during that cycle.
- byte_cnt increments on the same edge that ends the write cycle.
- done rises on the edge after the last write (no macro) or after the checksum compare (macro). busy falls on the same edge.
- start → busy high on the next edge.
- Frame length is 10 × CLKS_PER_BIT cycles. Back-to-back frames with no idle gap must be accepted.

## Configuration
- MEM_LOADER_CHECKSUM_EN defined:
  - After LOAD_LEN data bytes, the FSM enters L_CSUM and receives one extra byte, which is not written to memory.
  - csum_err is set if (sum + byte) mod 256 ≠ 0.
  - The FSM then goes to L_DONE.
- Undefined:
  - No L_CSUM state and no accumulator.
  - csum_err is tied 0.
  - The FSM goes L_LOAD → L_DONE directly.

## Test plan
- CLKS_PER_BIT=4, LOAD_LEN=4. Pulse start, send 0x11 0x22 0x33 0x44 → four one-cycle mem_we pulses at addr 0..3 with those data; byte_cnt=4, done=1, busy=0.
- Idle, cpu_addr=0x10, cpu_din=0xAB, cpu_we=1 → mem_* mirror cpu_* in the same cycle. During a load, cpu_we=1 → mem_we=0 except on loader write cycles.
- Send 0x55 with stop bit 0, then 0x66 → frame_err=1, no write for 0x55, 0x66 written at addr 0, byte_cnt=1.
- Assert rst after 2 of 4 bytes → busy=0, byte_cnt=0, done=0 next cycle. A subsequent start + 4 bytes completes normally.
- Pulse start while busy, and send a byte while done=1 → no effect on byte_cnt, no mem_we.
- Macro on: send 0x01 0x02 0x03 0x04 + 0xF6 → csum_err=0, done=1, 4 writes only. Checksum byte 0xF7 instead → csum_err=1.
